camera_frame_source: RTL and testbench



---
 rtl/camera_pkg.sv | 32 +++
 rtl/camera_pattern_gen.sv | 32 +++
 rtl/camera_frame_source.sv | 126 ++++++++++++
 tb/tb_camera_frame_source.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : camera_pkg
//  Description : Shared types and helpers for the synthetic camera source.
//                Holds the pixel size, the handshake state encoding and the
//                test-pattern pixel function.
//  Revision    : 1.0 - initial release
// ============================================================================
package camera_pkg;

    localparam int unsigned PIXEL_BITS = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        GEN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Test pattern: R = x, G = y, B = x + y, all modulo 256.
    // The callers pass only the low byte of each coordinate, because the
    // pattern wraps every 256 pixels.
    function automatic logic [PIXEL_BITS-1:0] pixel_rgb(input logic [7:0] x,
                                                        input logic [7:0] y);
        logic [7:0] sum;
        sum = x + y;
        return {x, y, sum};
    endfunction

endpackage

`default_nettype wire

// File: rtl/camera_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : camera_pattern_gen
//  Description : Combinational word builder. Turns the coordinate of the
//                leftmost pixel into one BUS_WIDTH word of BUS_WIDTH/24
//                consecutive pattern pixels. Pixel k sits in bits
//                [24k+23:24k].
//  Revision    : 1.0 - initial release
// ============================================================================
module camera_pattern_gen
    import camera_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 96,
    parameter int unsigned XW        = 10,
    parameter int unsigned YW        = 9
) (
    input  logic [XW-1:0]        x,
    input  logic [YW-1:0]        y,
    output logic [BUS_WIDTH-1:0] word
);

    localparam int unsigned c_ppw = BUS_WIDTH / PIXEL_BITS;

    // Each pixel slot gets its own column offset. The arithmetic is done
    // modulo 256, which is all that the pattern needs.
    for (genvar k = 0; k < c_ppw; k++) begin : g_pixel
        assign word[k*PIXEL_BITS +: PIXEL_BITS] = pixel_rgb(8'(x) + 8'(k), 8'(y));
    end

endmodule

`default_nettype wire

// File: rtl/camera_frame_source.sv
`default_nettype none
// ============================================================================
//  Module      : camera_frame_source
//  Description : Synthesizable image-sensor stand-in. Produces one frame of
//                RGB test-pattern pixels, one BUS_WIDTH word per request,
//                over a ready / in_progress / valid handshake. The last word
//                of the frame is flagged with frame_end.
//  Revision    : 1.0 - initial release
// ============================================================================
module camera_frame_source
    import camera_pkg::*;
#(
    parameter int unsigned BUS_WIDTH    = 96,
    parameter int unsigned FRAME_WIDTH  = 640,
    parameter int unsigned FRAME_HEIGHT = 480,
    parameter int unsigned LATENCY      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 recieve_ready,
    output logic                 in_progress,
    output logic [BUS_WIDTH-1:0] data,
    output logic                 data_valid,
    output logic                 frame_end
);

    localparam int unsigned c_ppw = BUS_WIDTH / PIXEL_BITS;
    localparam int unsigned c_xw  = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int unsigned c_yw  = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int unsigned c_cw  = (LATENCY      > 1) ? $clog2(LATENCY)      : 1;

    state_t                 r_state;
    logic [c_cw-1:0]        r_cnt;
    logic [c_xw-1:0]        r_x;
    logic [c_yw-1:0]        r_y;
    logic                   r_in_progress;
    logic                   r_data_valid;
    logic                   r_frame_end;
    logic [BUS_WIDTH-1:0]   r_data;

    logic [BUS_WIDTH-1:0]   w_word;
    logic                   w_last_col;
    logic                   w_last_row;

    camera_pattern_gen #(
        .BUS_WIDTH (BUS_WIDTH),
        .XW        (c_xw),
        .YW        (c_yw)
    ) u_pattern (
        .x    (r_x),
        .y    (r_y),
        .word (w_word)
    );

    assign w_last_col = ((32'(r_x) + c_ppw) == FRAME_WIDTH);
    assign w_last_row = (32'(r_y) == (FRAME_HEIGHT - 1));

    // Handshake FSM with latency countdown, pixel position and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_in_progress <= 1'b0;
            r_data_valid  <= 1'b0;
            r_frame_end   <= 1'b0;
            r_data        <= '0;
        end else begin
            case (r_state)
                // IDLE and HOLD accept a request identically; a held
                // frame_end means the next word starts a new frame.
                IDLE, HOLD: begin
                    if (recieve_ready) begin
                        r_state       <= ACK;
                        r_in_progress <= 1'b1;
                        r_data_valid  <= 1'b0;
                        r_frame_end   <= 1'b0;
                        if (r_frame_end) begin
                            r_x <= '0;
                            r_y <= '0;
                        end
                    end
                end
                // The consumer dropping its request starts production.
                ACK: begin
                    if (!recieve_ready) begin
                        r_state <= GEN;
                        r_cnt   <= c_cw'(LATENCY - 1);
                    end
                end
                GEN: begin
                    if (r_cnt == '0) begin
                        r_state       <= HOLD;
                        r_data        <= w_word;
                        r_data_valid  <= 1'b1;
                        r_in_progress <= 1'b0;
                        r_frame_end   <= w_last_col && w_last_row;
                        if (w_last_col) begin
                            r_x <= '0;
                            // Past the last line y parks until the restart.
                            if (!w_last_row) begin
                                r_y <= r_y + c_yw'(1);
                            end
                        end else begin
                            r_x <= r_x + c_xw'(c_ppw);
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cw'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_progress = r_in_progress;
    assign data_valid  = r_data_valid;
    assign frame_end   = r_frame_end;
    assign data        = r_data;

endmodule

`default_nettype wire

// File: tb/tb_camera_frame_source.sv
`default_nettype none
// ============================================================================
//  Module      : tb_camera_frame_source
//  Description : Self-checking bench for camera_frame_source (96-bit bus,
//                8x2 frame, latency 4). A transaction-level model predicts
//                every output on every cycle; directed and random phases
//                drive the request line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_camera_frame_source;

    localparam int BW  = 96;
    localparam int FW  = 8;
    localparam int FH  = 2;
    localparam int LAT = 4;
    localparam int PPW = BW / 24;
    localparam int WPL = FW / PPW;      // words per line
    localparam int WPF = WPL * FH;      // words per frame

    logic          clk;
    logic          rst;
    logic          recieve_ready;
    logic          in_progress;
    logic [BW-1:0] data;
    logic          data_valid;
    logic          frame_end;

    int checks   = 0;
    int failures = 0;

    camera_frame_source #(
        .BUS_WIDTH    (BW),
        .FRAME_WIDTH  (FW),
        .FRAME_HEIGHT (FH),
        .LATENCY      (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .recieve_ready (recieve_ready),
        .in_progress   (in_progress),
        .data          (data),
        .data_valid    (data_valid),
        .frame_end     (frame_end)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word n of a frame: line n / WPL, starting column (n % WPL) * PPW.
    function automatic logic [BW-1:0] exp_word(input int n);
        logic [BW-1:0] w;
        int x0;
        int y;
        x0 = (n % WPL) * PPW;
        y  = n / WPL;
        w  = '0;
        for (int k = 0; k < PPW; k++) begin
            w[24*k +: 24] = {8'((x0 + k) % 256), 8'(y % 256), 8'((x0 + k + y) % 256)};
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // busy: a request is accepted and no word has been delivered for it yet.
    // remaining: -1 while the consumer still holds its request, otherwise the
    // number of clock edges left until the word appears.
    bit            m_busy;
    int            m_remaining;
    int            m_words_done;   // words delivered in the current frame
    bit            m_valid;
    bit            m_fe;
    logic [BW-1:0] m_data;

    always @(posedge clk) begin
        if (rst) begin
            m_busy       = 1'b0;
            m_remaining  = -1;
            m_words_done = 0;
            m_valid      = 1'b0;
            m_fe         = 1'b0;
            m_data       = '0;
        end else if (!m_busy) begin
            if (recieve_ready) begin
                m_busy  = 1'b1;
                m_valid = 1'b0;
                m_fe    = 1'b0;
                if (m_words_done == WPF) m_words_done = 0;
            end
        end else if (m_remaining < 0) begin
            if (!recieve_ready) m_remaining = LAT;
        end else begin
            m_remaining--;
            if (m_remaining == 0) begin
                m_data      = exp_word(m_words_done);
                m_valid     = 1'b1;
                m_fe        = (m_words_done == WPF - 1);
                m_words_done++;
                m_busy      = 1'b0;
                m_remaining = -1;
            end
        end
    end

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        chk("in_progress", BW'(in_progress), BW'(m_busy));
        chk("data_valid",  BW'(data_valid),  BW'(m_valid));
        chk("frame_end",   BW'(frame_end),   BW'(m_fe));
        chk("data",        data,             m_data);
    end

    // ---------------- directed stimulus helpers ----------------
    // Raise the request, wait for acceptance, optionally stall, release it
    // and wait for the word. Latency is measured in edges after the release.
    task automatic do_request(input int stall, output logic [BW-1:0] w, output logic fe);
        int  n;
        bit  seen;
        @(posedge clk); #1;
        recieve_ready = 1'b1;
        seen = 1'b0;
        for (n = 0; n < 20 && !seen; n++) begin
            @(posedge clk); #1;
            seen = in_progress;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL accept_timeout: in_progress never rose, got 0 expected 1");
        end
        chk("accept_drops_valid", BW'({data_valid, frame_end}), BW'(2'b00));
        repeat (stall) begin
            @(posedge clk); #1;
        end
        if (stall > 0) chk("stall_hold", BW'({in_progress, data_valid}), BW'(2'b10));
        recieve_ready = 1'b0;
        @(posedge clk); #1;              // edge that samples the release
        seen = 1'b0;
        n = 0;
        while (!seen && n < 50) begin
            @(posedge clk); #1;
            n++;
            seen = data_valid;
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL valid_timeout: data_valid never rose, got 0 expected 1");
        end
        chk("latency", BW'(n), BW'(LAT));
        w  = data;
        fe = frame_end;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [BW-1:0] w;
        logic          fe;

        rst           = 1'b1;
        recieve_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", BW'({in_progress, data_valid, frame_end}), BW'(3'b000));
        chk("reset_data", data, '0);
        rst           = 1'b0;
        recieve_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_reset", BW'(in_progress), BW'(0));

        // Full frame of four words.
        do_request(0, w, fe);
        chk("word0", w, 96'h030003_020002_010001_000000);
        chk("word0_fe", BW'(fe), BW'(0));
        do_request(0, w, fe);
        chk("word1", w, 96'h070007_060006_050005_040004);
        do_request(0, w, fe);
        chk("word2", w, 96'h030104_020103_010102_000101);
        do_request(0, w, fe);
        chk("word3", w, 96'h070108_060107_050106_040105);
        chk("word3_fe", BW'(fe), BW'(1));
        repeat (5) @(posedge clk);
        #1;
        chk("fe_held", BW'({data_valid, frame_end}), BW'(2'b11));

        // Frame wrap: back to word 0.
        do_request(0, w, fe);
        chk("wrap_word0", w, 96'h030003_020002_010001_000000);
        chk("wrap_fe", BW'(fe), BW'(0));

        // Long stall in the acknowledge phase.
        do_request(20, w, fe);
        chk("stall_word1", w, 96'h070007_060006_050005_040004);

        // Reset while word 2 is being produced.
        @(posedge clk); #1;
        recieve_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        recieve_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midgen_busy", BW'(in_progress), BW'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset_outputs", BW'({in_progress, data_valid, frame_end}), BW'(3'b000));
        chk("midreset_data", data, '0);
        rst = 1'b0;
        do_request(0, w, fe);
        chk("after_reset_word0", w, 96'h030003_020002_010001_000000);

        // Random request traffic with occasional resets; the model checks it.
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            recieve_ready = ($urandom_range(0, 2) != 0);
            rst           = ($urandom_range(0, 199) == 0);
        end
        rst           = 1'b0;
        recieve_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
